// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority voting, false-start rejection,
// framing/overrun detection and rxne/read_done handshake. Define UART_RX_PARITY_EN for a parity bit.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 rx,
  input  logic                 read_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 flag_rxne,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int unsigned BIT_CNT_MAX = CLK_FREQ / BAUD - 1;
  localparam int unsigned HALF        = BIT_CNT_MAX / 2;
  localparam int unsigned CNT_W       = $clog2(BIT_CNT_MAX + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY_ODD > 1) begin : g_cfg_err
    $error("uart_rx_param: DATA_BITS must be 5..8 and PARITY_ODD 0 or 1");
  end

  logic                 rx_s1, rx_s2, rx_edge;
  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 smp0, smp1;
  logic                 stop_ok, frame_done;
  logic                 rd_q;
  logic                 busy, start_edge, strobe, maj, rd_fall;

  assign busy       = (state != IDLE);
  assign start_edge = (state == IDLE) && !rx_s2 && rx_edge;
  assign strobe     = busy && (cnt == CNT_W'(HALF + 1));
  // Third vote is the live synchronised line at the strobe count.
  assign maj        = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);
  assign rd_fall    = rd_q & ~read_done;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_edge <= 1'b1;
      rd_q    <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_edge <= rx_s2;
      rd_q    <= read_done;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt  <= '0;
      smp0 <= 1'b1;
      smp1 <= 1'b1;
    end else begin
      if (start_edge) begin
        cnt <= '0;
      end else if (busy) begin
        cnt <= (cnt == CNT_W'(BIT_CNT_MAX)) ? '0 : cnt + 1'b1;
      end
      if (busy && cnt == CNT_W'(HALF - 1)) smp0 <= rx_s2;
      if (busy && cnt == CNT_W'(HALF))     smp1 <= rx_s2;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      stop_ok    <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          bit_idx <= '0;
          if (start_edge) state <= START;
        end
        START: begin
          if (strobe) state <= maj ? IDLE : DATA;
        end
        DATA: begin
          if (strobe) begin
            shreg   <= {maj, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (strobe) begin
            par_bad <= maj ^ (^shreg) ^ (PARITY_ODD != 0);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          // Leave at mid-stop so a start bit straight after the stop bit is caught.
          if (strobe) begin
            stop_ok    <= maj;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      parity_err <= 1'b0;
    end else if (frame_done && (!flag_rxne || rd_fall)) begin
      parity_err <= par_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // A read_done fall in the same cycle as frame_done frees the buffer first.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_data     <= '0;
      flag_rxne   <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (frame_done) begin
      if (!flag_rxne || rd_fall) begin
        rx_data   <= shreg;
        frame_err <= !stop_ok;
        flag_rxne <= 1'b1;
        if (rd_fall) overrun_err <= 1'b0;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (rd_fall) begin
      flag_rxne   <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised self-checking bench for uart_rx_param: an 8-bit even-parity receiver (a)
// and a 7-bit odd-parity receiver (b), compared against a frame-level model.
module tb_uart_rx_param;

  localparam int unsigned CLKS_PER_BIT = 10;

  logic       sys_clk = 1'b0;
  logic       rst_a, rst_b, rx_a, rx_b, rd_a, rd_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       rxne_a, ferr_a, perr_a, ovr_a;
  logic       rxne_b, ferr_b, perr_b, ovr_b;

  always #5 sys_clk = ~sys_clk;

  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY_ODD(0)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(rst_a), .rx(rx_a), .read_done(rd_a),
    .rx_data(data_a), .flag_rxne(rxne_a), .frame_err(ferr_a),
    .parity_err(perr_a), .overrun_err(ovr_a)
  );

  uart_rx_param #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY_ODD(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(rst_b), .rx(rx_b), .read_done(rd_b),
    .rx_data(data_b), .flag_rxne(rxne_b), .frame_err(ferr_b),
    .parity_err(perr_b), .overrun_err(ovr_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model of each receiver's visible state
  int         nbits [2] = '{8, 7};
  bit         odd   [2] = '{1'b0, 1'b1};
  logic [7:0] m_data [2];
  bit         m_rxne [2];
  bit         m_ferr [2];
  bit         m_perr [2];
  bit         m_ovr  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int sel);
    m_data[sel] = 8'h00;
    m_rxne[sel] = 1'b0;
    m_ferr[sel] = 1'b0;
    m_perr[sel] = 1'b0;
    m_ovr[sel]  = 1'b0;
  endtask

  task automatic model_frame(input int sel, input logic [7:0] d, input bit stop_v, input bit perr);
    if (!m_rxne[sel]) begin
      m_data[sel] = d;
      m_ferr[sel] = !stop_v;
      m_perr[sel] = perr;
      m_rxne[sel] = 1'b1;
    end else begin
      m_ovr[sel] = 1'b1;
    end
  endtask

  task automatic check_dut(input int sel);
    if (sel == 0) begin
      check("a.rx_data",     {24'd0, data_a}, {24'd0, m_data[0]});
      check("a.flag_rxne",   {31'd0, rxne_a}, {31'd0, m_rxne[0]});
      check("a.frame_err",   {31'd0, ferr_a}, {31'd0, m_ferr[0]});
      check("a.parity_err",  {31'd0, perr_a}, {31'd0, m_perr[0]});
      check("a.overrun_err", {31'd0, ovr_a},  {31'd0, m_ovr[0]});
    end else begin
      check("b.rx_data",     {25'd0, data_b}, {24'd0, m_data[1]});
      check("b.flag_rxne",   {31'd0, rxne_b}, {31'd0, m_rxne[1]});
      check("b.frame_err",   {31'd0, ferr_b}, {31'd0, m_ferr[1]});
      check("b.parity_err",  {31'd0, perr_b}, {31'd0, m_perr[1]});
      check("b.overrun_err", {31'd0, ovr_b},  {31'd0, m_ovr[1]});
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CLKS_PER_BIT) @(negedge sys_clk);
  endtask

  task automatic do_read(input int sel);
    if (sel == 0) rd_a = 1'b0;
    else          rd_b = 1'b0;
    repeat (2) @(negedge sys_clk);
    if (sel == 0) rd_a = 1'b1;
    else          rd_b = 1'b1;
    @(negedge sys_clk);
    m_rxne[sel] = 1'b0;
    m_ovr[sel]  = 1'b0;
  endtask

  // Drives one whole frame; flip inverts the correct parity bit when parity is built in.
  task automatic send_frame(input int sel, input logic [7:0] d_in, input bit stop_v, input bit flip);
    logic [7:0] d;
    bit         perr;
    int         ones;
    bit         pbit;
    d    = d_in % 8'((1 << nbits[sel]) - 1 + 1);
    ones = 0;
    perr = 1'b0;
    set_rx(sel, 1'b0);
    wait_bits(1);
    for (int i = 0; i < nbits[sel]; i++) begin
      set_rx(sel, d[i]);
      if (d[i]) ones++;
      wait_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    pbit = ((ones % 2) == 1) ^ odd[sel];
    set_rx(sel, pbit ^ flip);
    wait_bits(1);
    perr = ((pbit ^ flip) != pbit);
`else
    pbit = flip & (ones < 0);
    perr = pbit;
`endif
    set_rx(sel, stop_v);
    wait_bits(1);
    set_rx(sel, 1'b1);
    model_frame(sel, d, stop_v, perr);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    rx_a  = 1'b1; rx_b  = 1'b1;
    rd_a  = 1'b1; rd_b  = 1'b1;
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge sys_clk);
    check_dut(0);
    check_dut(1);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Clean 0xA5
    send_frame(0, 8'hA5, 1'b1, 1'b0);
    repeat (5) @(negedge sys_clk);
    check_dut(0);
    do_read(0);
    check_dut(0);
    wait_bits(1);

    // False start: short low pulse, then a frame proves the receiver is idle again
    set_rx(0, 1'b0);
    repeat (3) @(negedge sys_clk);
    set_rx(0, 1'b1);
    wait_bits(3);
    check_dut(0);

    // Stop bit driven low
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    repeat (5) @(negedge sys_clk);
    check_dut(0);
    do_read(0);
    wait_bits(1);

    // Back-to-back frames without a read
    send_frame(0, 8'h11, 1'b1, 1'b0);
    send_frame(0, 8'h22, 1'b1, 1'b0);
    repeat (5) @(negedge sys_clk);
    check_dut(0);
    do_read(0);
    check_dut(0);
    wait_bits(1);

`ifdef UART_RX_PARITY_EN
    send_frame(0, 8'h07, 1'b1, 1'b1);
    repeat (5) @(negedge sys_clk);
    check_dut(0);
    do_read(0);
    wait_bits(1);
    send_frame(0, 8'h07, 1'b1, 1'b0);
    repeat (5) @(negedge sys_clk);
    check_dut(0);
    do_read(0);
    wait_bits(1);
`endif

    // Randomised traffic on receiver a
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      bit         sv, fl;
      int         gap;
      d   = 8'($urandom);
      sv  = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 3) == 0);
      send_frame(0, d, sv, fl);
      gap = sv ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      if (gap > 0) begin
        repeat (5) @(negedge sys_clk);
        check_dut(0);
        if ($urandom_range(0, 1) == 1) begin
          do_read(0);
          check_dut(0);
        end
        wait_bits(gap);
      end
    end
    wait_bits(2);
    check_dut(0);

    // Receiver b: 7-bit frame, then reset in the middle of the next frame
    send_frame(1, 8'h55, 1'b1, 1'b0);
    repeat (5) @(negedge sys_clk);
    check_dut(1);
    set_rx(1, 1'b0);
    wait_bits(1);
    for (int i = 0; i < 3; i++) begin
      set_rx(1, 1'(i % 2));
      wait_bits(1);
    end
    rst_b = 1'b0;
    set_rx(1, 1'b1);
    model_reset(1);
    repeat (2) @(negedge sys_clk);
    check_dut(1);
    repeat (5) @(negedge sys_clk);
    rst_b = 1'b1;
    wait_bits(2);
    check_dut(1);
    send_frame(1, 8'h2A, 1'b1, 1'b0);
    repeat (5) @(negedge sys_clk);
    check_dut(1);
    do_read(1);
    wait_bits(1);

    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      bit         fl;
      d  = 8'($urandom);
      fl = ($urandom_range(0, 2) == 0);
      send_frame(1, d, 1'b1, fl);
      repeat (5) @(negedge sys_clk);
      check_dut(1);
      if ($urandom_range(0, 1) == 1) do_read(1);
      wait_bits(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, the next generation of the fixed 8N1 RS232 receiver. Adds configurable clock/baud, data width (5..8), 3-sample majority voting, false-start rejection, stop-bit framing check, overrun detection and optional parity. Sits between the synchronised pad input and the consumer logic, using the same rxne/read_done handshake as the existing receiver.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s
DATA_BITS, 8, data bits per frame, legal 5..8, LSB first
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only when UART_RX_PARITY_EN is defined
Derived (localparam): BIT_CNT_MAX = CLK_FREQ/BAUD - 1; HALF = BIT_CNT_MAX/2; counter width = $clog2(BIT_CNT_MAX+1)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
rx  in  1  serial line, idle high, asynchronous to sys_clk
read_done  in  1  consumer acknowledge; a 1->0 transition clears flag_rxne
rx_data  out  DATA_BITS  last accepted frame
flag_rxne  out  1  receive buffer not empty
frame_err  out  1  stop bit of the frame in rx_data sampled 0
parity_err  out  1  parity mismatch on the frame in rx_data
overrun_err  out  1  sticky: a frame completed while flag_rxne = 1

Behaviour:
- Reset: rx_data = 0, flag_rxne = 0, all error outputs = 0, FSM = IDLE, sync flops = 1, read_done register = 1.
- Input: rx passes through 2 sync flops plus 1 edge flop; start edge = sync = 0 and edge flop = 1, detected only in IDLE.
- Bit counter: cleared to 0 on the start-edge cycle; counts 0..BIT_CNT_MAX and wraps to 0 while the FSM is not IDLE.
- Sampling: the synchronised line is captured at counts HALF-1, HALF and HALF+1. At count HALF+1 a sample strobe fires. The bit value is the 2-of-3 majority.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- START: strobe with majority 1 = false start; go to IDLE with no outputs changed. Majority 0 goes to DATA.
- DATA: shift the majority into the MSB of a DATA_BITS shift register on each strobe. After DATA_BITS strobes go to PARITY (macro defined) or STOP.
- STOP: on the strobe, go to IDLE immediately. Latch stop_ok = majority and raise a one-cycle frame_done. Returning to IDLE at mid-stop allows back-to-back frames with zero idle gap.
- Cycle after frame_done:
  - flag_rxne = 0: rx_data <= shift register; frame_err <= !stop_ok; parity_err <= mismatch; flag_rxne <= 1.
  - flag_rxne = 1: rx_data, frame_err and parity_err hold; overrun_err <= 1; flag_rxne stays 1.
- Clear: a 1->0 transition on read_done (registered) drives flag_rxne and overrun_err to 0. frame_err and parity_err hold until the next accepted frame.
- Simultaneous frame_done and read_done falling edge: the clear is applied first. The new frame is loaded, flag_rxne = 1, and no overrun is set.
- Reset asserted mid-frame: immediate return to the reset state; the partial frame is discarded.
- Errored frames are still delivered (flag_rxne = 1) with the error bits set.

Optional Feature:
UART_RX_PARITY_EN
- Defined: a PARITY state follows DATA and samples one bit. The expected value is XOR of the data bits for even parity, or its inverse when PARITY_ODD = 1. parity_err reflects the mismatch on the frame loaded into rx_data.
- Undefined: there is no PARITY state, the frame is start+data+stop, and parity_err is tied to 0.

Test Plan:
(Bench uses CLK_FREQ = 1_000_000 and BAUD = 100_000, giving 10 clocks per bit.)
- 8N1, send 0xA5 -> one cycle after mid-stop, rx_data = 0xA5, flag_rxne = 1, frame_err = parity_err = overrun_err = 0.
- rx low for 3 clocks, then high -> no frame; FSM back in IDLE after the START strobe; flag_rxne stays 0.
- Send 0x3C with stop bit driven 0 -> rx_data = 0x3C, flag_rxne = 1, frame_err = 1.
- Send 0x11 then 0x22 back-to-back with no idle, no read_done -> rx_data = 0x11, overrun_err = 1. Then toggle read_done 1->0 -> flag_rxne = 0, overrun_err = 0.
- UART_RX_PARITY_EN defined, PARITY_ODD = 0, send 0x07 with parity bit 0 -> parity_err = 1. Resend with parity bit 1 -> parity_err = 0.
- DATA_BITS = 7, send 0x55, then assert sys_rst_n low mid-way through a second frame -> first frame gives rx_data = 7'h55. After reset, all outputs = 0 and the next clean frame is received correctly.
